// File: rtl/ham_enc_stream.sv
// ham_enc_stream: streaming Hamming (17,12) encoder with an output FIFO.
// Words come in over valid/ready and are encoded, with an optional single-bit
// error injected. The codeword is queued and then presented over valid/ready.
// in_ready depends only on registered state, so there is no combinational
// path from out_ready back to in_ready.

module ham_enc_stream #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [11:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             inj_en,
    input  logic [4:0]       inj_pos,
    output logic [16:0]      out_cw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    // Place the data bits and compute the five even-parity bits.
    function automatic logic [16:0] ham_encode(input logic [11:0] d);
        logic [16:0] cw;
        cw      = 17'd0;
        cw[2]   = d[0];
        cw[4]   = d[1];
        cw[5]   = d[2];
        cw[6]   = d[3];
        cw[8]   = d[4];
        cw[9]   = d[5];
        cw[10]  = d[6];
        cw[11]  = d[7];
        cw[12]  = d[8];
        cw[13]  = d[9];
        cw[14]  = d[10];
        cw[16]  = d[11];
        cw[0]   = ^{cw[2], cw[4], cw[6], cw[8], cw[10], cw[12], cw[14], cw[16]};
        cw[1]   = ^{cw[2], cw[5], cw[6], cw[9], cw[10], cw[13], cw[14]};
        cw[3]   = ^{cw[4], cw[5], cw[6], cw[11], cw[12], cw[13], cw[14]};
        cw[7]   = ^cw[14:8];
        cw[15]  = cw[16];
        return cw;
    endfunction

    // Flip one codeword bit; positions beyond 16 leave the word untouched.
    function automatic logic [16:0] inject(input logic [16:0] cw, input logic en,
                                           input logic [4:0] pos);
        logic [16:0] res;
        if (en && (pos <= 5'd16)) begin
            res = cw ^ (17'd1 << pos);
        end else begin
            res = cw;
        end
        return res;
    endfunction

    logic [16:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             r_rdy_en;
    logic [CNT_W-1:0] r_word_cnt;

    logic             w_push;
    logic             w_pop;
    logic [16:0]      w_cw;

    // Handshake qualifiers and the codeword that would be written this cycle.
    always_comb begin
        w_push = in_valid && in_ready;
        w_pop  = out_valid && out_ready;
        w_cw   = inject(ham_encode(in_data), inj_en, inj_pos);
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        in_ready  = r_rdy_en && (r_count < DEPTH_C);
        out_valid = (r_count != (AW+1)'(0));
        out_cw    = r_mem[r_rptr];
        word_cnt  = r_word_cnt;
    end

    // FIFO storage, pointers, occupancy, ready enable and accept counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 17'd0;
            end
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_rdy_en   <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_push) begin
                r_mem[r_wptr] <= w_cw;
                r_wptr        <= r_wptr + AW'(1);
                r_word_cnt    <= r_word_cnt + CNT_W'(1);
            end else begin
                r_wptr     <= r_wptr;
                r_word_cnt <= r_word_cnt;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end else begin
                r_rptr <= r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
